// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the framed serial receiver: FSM state encodings.
package serial_frame_rx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;   // line idle, waiting for a start bit
    localparam logic [1:0] ST_DATA = 2'd1;   // collecting data bits
    localparam logic [1:0] ST_STOP = 2'd2;   // next sampled bit is the stop bit
    // 2'd3 is unused; the FSM recovers from it to ST_IDLE.

endpackage

// File: rtl/serial_frame_rx_sipo_shift.sv
// Serial-in parallel-out shift register. After WIDTH shifts the first bit
// shifted in sits at q[0] (LSB_FIRST=1) or at q[WIDTH-1] (LSB_FIRST=0).
module sipo_shift #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             si,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            // New bits enter at the top and walk down, so the oldest ends at bit 0.
            assign w_q_next = {si, r_q[WIDTH-1:1]};
        end else begin : g_msb_first
            // New bits enter at the bottom and walk up, so the oldest ends at the top.
            assign w_q_next = {r_q[WIDTH-2:0], si};
        end
    endgenerate

    // Shift on enabled edges, clear on reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (shift_en) begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit (0), WIDTH data bits, stop bit (1), timed
// by an external bit_en strobe. Good words appear on po with a one-clock
// po_valid; a low stop bit gives a one-clock frame_err and po is kept.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             bit_en,
    input  logic             si,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] r_po;
    logic             r_po_valid;
    logic             r_frame_err;
    logic             r_busy;
    logic [WIDTH-1:0] w_shift_q;
    logic             w_shift_en;
    logic             w_load_po;
    logic             w_set_err;
    logic             w_busy_next;

    sipo_shift #(
        .WIDTH    (WIDTH),
        .LSB_FIRST(LSB_FIRST)
    ) u_sipo (
        .clk     (clk),
        .clr     (clr),
        .shift_en(w_shift_en),
        .si      (si),
        .q       (w_shift_q)
    );

    // State and bit counter registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and counter logic; only bit_en edges advance a frame.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bit_en && !si) begin
                    w_state_next = ST_DATA;
                    w_cnt_next   = '0;
                end
            end
            ST_DATA: begin
                if (bit_en) begin
                    // Counter reaches WIDTH at most, so it never wraps.
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_en) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: shift enable, word load, error strobe and next busy level.
    always_comb begin
        w_shift_en  = bit_en && (r_state == ST_DATA);
        w_load_po   = bit_en && (r_state == ST_STOP) && si;
        w_set_err   = bit_en && (r_state == ST_STOP) && !si;
        w_busy_next = (w_state_next == ST_DATA) || (w_state_next == ST_STOP);
    end

    // Registered outputs; strobes are recomputed every clock so they last one cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_po        <= '0;
            r_po_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_po_valid  <= w_load_po;
            r_frame_err <= w_set_err;
            r_busy      <= w_busy_next;
            if (w_load_po) begin
                r_po <= w_shift_q;
            end
        end
    end

    assign po        = r_po;
    assign po_valid  = r_po_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench: two receivers (LSB-first and MSB-first) share one line.
// Stimulus pushes the expected word/error per frame; a negedge monitor pops on
// each strobe. Busy and po hold are checked every clock against the model.
`timescale 1ns/1ps
module tb_serial_frame_rx;

    typedef struct {
        logic       is_err;
        logic [7:0] word;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       bit_en = 1'b0;
    logic       si = 1'b1;
    logic [7:0] po0, po1;
    logic       v0, v1, e0, e1, b0, b1;

    int   checks = 0;
    int   errors = 0;
    bit   armed = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] last0 = 8'h00;
    logic [7:0] last1 = 8'h00;
    logic       exp_busy = 1'b0;
    logic       prev_strobe0 = 1'b0;
    logic       prev_strobe1 = 1'b0;

    always #5 clk = ~clk;

    serial_frame_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .clr(clr), .bit_en(bit_en), .si(si),
        .po(po0), .po_valid(v0), .frame_err(e0), .busy(b0)
    );

    serial_frame_rx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .clr(clr), .bit_en(bit_en), .si(si),
        .po(po1), .po_valid(v1), .frame_err(e1), .busy(b1)
    );

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7 - i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Busy level and held po, compared after every clock edge.
    task automatic check_state();
        if (armed) begin
            chk("busy_lsb", {7'd0, b0}, {7'd0, exp_busy});
            chk("busy_msb", {7'd0, b1}, {7'd0, exp_busy});
            chk("po_hold_lsb", po0, last0);
            chk("po_hold_msb", po1, last1);
        end
    endtask

    task automatic tick(input logic en, input logic s, input logic c);
        @(negedge clk);
        check_state();
        bit_en = en;
        si     = s;
        clr    = c;
    endtask

    // One bit period: gap-1 disabled clocks carrying random junk, then the strobe.
    task automatic send_bit(input logic b, input int gap);
        for (int k = 1; k < gap; k++) tick(1'b0, 1'($urandom), 1'b0);
        tick(1'b1, b, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_ok, input int gap);
        exp_t x0, x1;
        send_bit(1'b0, gap);
        exp_busy = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(data[i], gap);
        send_bit(stop_ok, gap);
        exp_busy = 1'b0;
        if (stop_ok) begin
            last0 = data;
            last1 = rev8(data);
            x0.is_err = 1'b0;
        end else begin
            x0.is_err = 1'b1;
        end
        x1.is_err = x0.is_err;
        x0.word = last0;
        x1.word = last1;
        q0.push_back(x0);
        q1.push_back(x1);
        $display("frame data=%h stop=%0d gap=%0d exp_lsb=%h exp_msb=%h err=%0d",
                 data, stop_ok, gap, x0.word, x1.word, x0.is_err);
    endtask

    task automatic mon(input int id, input logic v, input logic e, input logic [7:0] p);
        exp_t x;
        logic prev;
        prev = (id == 0) ? prev_strobe0 : prev_strobe1;
        if (v || e) begin
            checks++;
            if (v && e) begin
                errors++;
                $display("FAIL strobe_excl dut%0d: valid=%0d err=%0d expected not both", id, v, e);
            end
            if (prev) begin
                errors++;
                $display("FAIL strobe_width dut%0d: strobe high two clocks, expected one", id);
            end
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_strobe dut%0d: valid=%0d err=%0d po=%h, expected none", id, v, e, p);
            end else begin
                x = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk((id == 0) ? "strobe_kind_lsb" : "strobe_kind_msb", {7'd0, e}, {7'd0, x.is_err});
                chk((id == 0) ? "po_word_lsb" : "po_word_msb", p, x.word);
                $display("strobe dut%0d valid=%0d err=%0d po=%h", id, v, e, p);
            end
        end
        if (id == 0) prev_strobe0 = v || e;
        else         prev_strobe1 = v || e;
    endtask

    // Monitor: pops the scoreboard whenever either receiver strobes.
    always @(negedge clk) begin
        if (armed) begin
            mon(0, v0, e0, po0);
            mon(1, v1, e1, po1);
        end
    end

    initial begin
        int idle;
        logic [7:0] d;
        repeat (2) @(negedge clk);
        armed = 1'b1;                    // reset values now checked on every clock
        tick(1'b0, 1'b1, 1'b0);

        // A5 at full rate; same bit sequence also yields A5 MSB-first.
        send_frame(8'hA5, 1'b1, 1);
        // Bad stop bit: error strobe, po keeps A5.
        send_frame(8'h3C, 1'b0, 1);
        send_bit(1'b1, 1);
        // Slow bit rate.
        send_frame(8'h9A, 1'b1, 4);

        // Reset after four data bits drops the frame and clears po.
        send_bit(1'b0, 1);
        exp_busy = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1);
        tick(1'b1, 1'b0, 1'b1);
        exp_busy = 1'b0;
        last0 = 8'h00;
        last1 = 8'h00;
        tick(1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 2);

        // Idle line, then back-to-back frames.
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1 + (i % 3));
        send_frame(8'h01, 1'b1, 1);
        send_frame(8'hFF, 1'b1, 1);
        // Error frame followed immediately by a new start bit.
        send_frame(8'h77, 1'b0, 1);
        send_frame(8'hC3, 1'b1, 1);

        // Random frames, gaps and idle periods.
        for (int n = 0; n < 40; n++) begin
            idle = $urandom_range(0, 3);
            for (int k = 0; k < idle; k++) send_bit(1'b1, $urandom_range(1, 4));
            d = 8'($urandom);
            send_frame(d, ($urandom_range(0, 4) != 0), $urandom_range(1, 4));
        end

        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'b0);
        chk("scoreboard_empty_lsb", 8'(q0.size()), 8'd0);
        chk("scoreboard_empty_msb", 8'(q1.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
